// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the word-indexed PC and issues requests to
// instruction memory over a req/gnt/rvalid handshake. It also drives the IF/ID
// register, handles stalls, and drops stale responses after a redirect.
// Optional build macro FETCH_PERF_EN adds three 32-bit event counters.
module fetch_pc_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            jump,
  input  logic [XLEN-1:0] next,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_redirect_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StHold,
    StDrop
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] hold_instr_q, hold_instr_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;

  // A word is handed to IF/ID this cycle (from memory or from the hold buffer)
  logic            deliver;
  logic [XLEN-1:0] deliver_instr;
  logic [XLEN-1:0] deliver_pc;

  // Fetch sequencing: next state, PC update and hold-buffer capture
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;
    deliver       = 1'b0;
    deliver_instr = imem_rdata;
    deliver_pc    = pc_q;
    unique case (state_q)
      StIdle: begin
        state_d = StReq;
        if (jump) pc_d = next;
      end
      StReq: begin
        if (jump) begin
          pc_d = next;
          // A granted request now belongs to the old stream; its response must be dropped
          if (imem_gnt) state_d = StDrop;
        end else if (imem_gnt) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (jump) begin
          pc_d    = next;
          state_d = imem_rvalid ? StReq : StDrop;
        end else if (imem_rvalid) begin
          if (stall) begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = pc_q;
            state_d      = StHold;
          end else begin
            deliver = 1'b1;
            state_d = StReq;
          end
        end
      end
      StHold: begin
        if (jump) begin
          pc_d    = next;
          state_d = StReq;
        end else if (!stall) begin
          deliver       = 1'b1;
          deliver_instr = hold_instr_q;
          deliver_pc    = hold_pc_q;
          state_d       = StReq;
        end
      end
      StDrop: begin
        if (jump) pc_d = next;
        // Outstanding response retires the stale request; resume at the latest target
        if (imem_rvalid) state_d = StReq;
      end
      default: state_d = StIdle;
    endcase
    if (deliver) pc_d = deliver_pc + XLEN'(1);
  end

  // IF/ID next value: redirect flushes, stall holds, otherwise load or bubble
  always_comb begin
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if (jump) begin
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
    end else if (stall) begin
      if_valid_d = if_valid_q;
    end else if (deliver) begin
      if_valid_d = 1'b1;
      if_instr_d = deliver_instr;
      if_pc_d    = deliver_pc;
    end else begin
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
    end
  end

  // State, PC, hold buffer and IF/ID registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= NOP_INSTR;
      if_pc_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
    end
  end

  // Memory request side follows the state and PC directly
  always_comb begin
    imem_req  = (state_q == StReq);
    imem_addr = pc_q;
    if_valid  = if_valid_q;
    if_instr  = if_instr_q;
    if_pc     = if_pc_q;
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_redirect_q, perf_stall_q;

  // Event counters; wrap naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q    <= '0;
      perf_redirect_q <= '0;
      perf_stall_q    <= '0;
    end else begin
      perf_fetch_q    <= perf_fetch_q + {31'b0, (deliver & ~jump & ~stall)};
      perf_redirect_q <= perf_redirect_q + {31'b0, jump};
      perf_stall_q    <= perf_stall_q + {31'b0, (stall & if_valid_q)};
    end
  end

  // Counter outputs
  always_comb begin
    perf_fetch_cnt    = perf_fetch_q;
    perf_redirect_cnt = perf_redirect_q;
    perf_stall_cnt    = perf_stall_q;
  end
`endif

endmodule
